// File: rtl/chacha_pkg.sv
// Shared ChaCha types, constants and word/row helpers used by the block core and round datapath.
package chacha_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] row_t;
  typedef word_t [15:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    OUT
  } fsm_e;

  // "expand 32-byte k" as little-endian words; SIGMA[0] is state word 0.
  localparam logic [3:0][31:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Row r of the 4x4 matrix: {w(4r+3), w(4r+2), w(4r+1), w(4r)}.
  function automatic row_t state_pack(input state_t s, input int unsigned r);
    return s[4*r +: 4];
  endfunction

  function automatic state_t state_unpack(input row_t a, input row_t b, input row_t c, input row_t d);
    return {d, c, b, a};
  endfunction

  function automatic state_t init_state(input logic [255:0] key, input word_t counter,
                                        input logic [95:0] nonce);
    return {nonce, counter, key, SIGMA};
  endfunction

endpackage

// File: rtl/round.sv
// One combinational ChaCha round: four parallel quarter-rounds on columns (op_type=0) or diagonals (op_type=1).
module round
  import chacha_pkg::*;
(
  input  logic op_type,
  input  row_t input_a,
  input  row_t input_b,
  input  row_t input_c,
  input  row_t input_d,
  output row_t output_a,
  output row_t output_b,
  output row_t output_c,
  output row_t output_d
);

  function automatic logic [127:0] quarter(input word_t a, input word_t b, input word_t c, input word_t d);
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  word_t qa [4];
  word_t qb [4];
  word_t qc [4];
  word_t qd [4];

  // Lane i always owns a[i]; on diagonal rounds b, c, d are taken from lanes i+1, i+2, i+3.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [1:0] ib, ic, id;
    assign ib = op_type ? 2'(i + 1) : 2'(i);
    assign ic = op_type ? 2'(i + 2) : 2'(i);
    assign id = op_type ? 2'(i + 3) : 2'(i);
    assign {qa[i], qb[i], qc[i], qd[i]} = quarter(input_a[32*i +: 32], input_b[32*ib +: 32],
                                                  input_c[32*ic +: 32], input_d[32*id +: 32]);
  end

  // Scatter back: output word j of row b came from lane j-1, row c from j-2, row d from j-3.
  for (genvar j = 0; j < 4; j++) begin : g_out
    logic [1:0] sb, sc, sd;
    assign sb = op_type ? 2'(j + 3) : 2'(j);
    assign sc = op_type ? 2'(j + 2) : 2'(j);
    assign sd = op_type ? 2'(j + 1) : 2'(j);
    assign output_a[32*j +: 32] = qa[j];
    assign output_b[32*j +: 32] = qb[sb];
    assign output_c[32*j +: 32] = qc[sc];
    assign output_d[32*j +: 32] = qd[sd];
  end

endmodule

// File: rtl/chacha_block_core.sv
// Sequential ChaCha block function: iterates the round datapath, adds the initial state,
// and hands the 512-bit keystream block out over a valid/ready port.
module chacha_block_core
  import chacha_pkg::*;
#(
  parameter int DOUBLE_ROUNDS = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [255:0] key,
  input  logic [31:0]  counter,
  input  logic [95:0]  nonce,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic [511:0] keystream,
  output logic         busy
);

  localparam int NUM_ROUNDS = 2 * DOUBLE_ROUNDS;
  localparam int RCNT_W     = (NUM_ROUNDS > 2) ? $clog2(NUM_ROUNDS) : 1;
  localparam logic [RCNT_W-1:0] LAST_ROUND = RCNT_W'(NUM_ROUNDS - 1);

  fsm_e              state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q;
  state_t            init_q, work_q, ks_q;
  state_t            round_state, final_sum;
  row_t              row_a, row_b, row_c, row_d;
  logic              accept;

  round u_round (
    .op_type  (rcnt_q[0]),
    .input_a  (state_pack(work_q, 0)),
    .input_b  (state_pack(work_q, 1)),
    .input_c  (state_pack(work_q, 2)),
    .input_d  (state_pack(work_q, 3)),
    .output_a (row_a),
    .output_b (row_b),
    .output_c (row_c),
    .output_d (row_d)
  );

  assign round_state = state_unpack(row_a, row_b, row_c, row_d);

  // Feed-forward: per-word add modulo 2^32, carries do not cross word boundaries.
  always_comb begin
    final_sum = '0;
    for (int i = 0; i < 16; i++) begin
      final_sum[i] = round_state[i] + init_q[i];
    end
  end

  assign start_ready = (state_q == IDLE);
  assign ks_valid    = (state_q == OUT);
  assign busy        = (state_q == ROUND) || (state_q == OUT);
  assign keystream   = ks_q;
  assign accept      = start_valid && start_ready;

  always_comb begin
    // NOTE: default assigned first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ROUND;
      ROUND:   if (rcnt_q == LAST_ROUND) state_d = OUT;
      OUT:     if (ks_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: every state register is cleared so an aborted block leaves no key material behind.
      state_q <= IDLE;
      rcnt_q  <= '0;
      init_q  <= '0;
      work_q  <= '0;
      ks_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            init_q <= init_state(key, counter, nonce);
            work_q <= init_state(key, counter, nonce);
            rcnt_q <= '0;
          end
        end
        ROUND: begin
          work_q <= round_state;
          if (rcnt_q == LAST_ROUND) begin
            ks_q   <= final_sum;
            rcnt_q <= '0;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_block_core.sv
// Self-checking bench for chacha_block_core: RFC vectors, random blocks against a word-array
// reference model, backpressure, back-to-back, mid-block reset and a ChaCha8 build.
module tb_chacha_block_core;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start_valid, start_ready, ks_valid, ks_ready, busy;
  logic [255:0] key_i;
  logic [31:0]  counter_i;
  logic [95:0]  nonce_i;
  logic [511:0] keystream;
  logic         start_valid8, start_ready8, ks_valid8, ks_ready8, busy8;
  logic [511:0] keystream8;

  int total = 0;
  int bad   = 0;

  chacha_block_core dut (
    .clock(clock), .reset_n(reset_n), .start_valid(start_valid), .start_ready(start_ready),
    .key(key_i), .counter(counter_i), .nonce(nonce_i), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .keystream(keystream), .busy(busy)
  );

  chacha_block_core #(.DOUBLE_ROUNDS(4)) dut8 (
    .clock(clock), .reset_n(reset_n), .start_valid(start_valid8), .start_ready(start_ready8),
    .key(key_i), .counter(counter_i), .nonce(nonce_i), .ks_valid(ks_valid8), .ks_ready(ks_ready8),
    .keystream(keystream8), .busy(busy8)
  );

  always #5 clock = ~clock;

  // RFC quarter-round index sets: four columns then four diagonals.
  localparam int QI [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                               '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    a += b; d ^= a; d = rl(d, 16);
    c += d; b ^= c; b = rl(b, 12);
    a += b; d ^= a; d = rl(d, 8);
    c += d; b ^= c; b = rl(b, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_ref(input logic [255:0] k, input logic [31:0] ctr,
                                              input logic [95:0] n, input int dr);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = ctr;
    for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
    x = s;
    for (int d = 0; d < dr; d++)
      for (int q = 0; q < 8; q++)
        {x[QI[q][0]], x[QI[q][1]], x[QI[q][2]], x[QI[q][3]]} =
          qr_ref(x[QI[q][0]], x[QI[q][1]], x[QI[q][2]], x[QI[q][3]]);
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  function automatic logic [255:0] rfc_key();
    logic [255:0] k;
    for (int i = 0; i < 32; i++) k[8*i +: 8] = 8'(i);
    return k;
  endfunction

  // Called at #1 after an edge with the core idle; returns once ks_valid is seen (or budget expires).
  task automatic start_block(input logic [255:0] k, input logic [31:0] ctr, input logic [95:0] n,
                             output logic [511:0] ks, output int lat);
    key_i = k; counter_i = ctr; nonce_i = n; start_valid = 1'b1;
    total++;
    if (start_ready !== 1'b1) begin bad++; $display("FAIL start_ready_idle got=%0b want=1", start_ready); end
    @(posedge clock); #1;
    start_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_accept got=%0b want=1", busy); end
    lat = 0;
    while (ks_valid !== 1'b1 && lat < 200) begin @(posedge clock); #1; lat++; end
    ks = keystream;
    total++;
    if (ks_valid !== 1'b1) begin bad++; $display("FAIL ks_valid_timeout got=%0b want=1", ks_valid); end
  endtask

  task automatic finish_block();
    ks_ready = 1'b1;
    @(posedge clock); #1;
    ks_ready = 1'b0;
    total++;
    if (ks_valid !== 1'b0 || start_ready !== 1'b1)
      begin bad++; $display("FAIL release got valid=%0b ready=%0b want 0/1", ks_valid, start_ready); end
  endtask

  task automatic test_reset();
    total++;
    if (ks_valid !== 1'b0 || busy !== 1'b0 || keystream !== '0 || start_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state got valid=%0b busy=%0b ready=%0b ks0=%h", ks_valid, busy, start_ready,
               keystream[31:0]);
    end
  endtask

  task automatic test_rfc();
    logic [511:0] ks;
    int lat;
    start_block(rfc_key(), 32'd1, {32'h00000000, 32'h4a000000, 32'h09000000}, ks, lat);
    total++;
    if (ks[127:0] !== {32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110})
      begin bad++; $display("FAIL rfc_words got=%h want=c47120a31fdd0f5015593bd1e4e7f110", ks[127:0]); end
    total++;
    if (ks !== chacha_ref(rfc_key(), 32'd1, {32'h0, 32'h4a000000, 32'h09000000}, 10))
      begin bad++; $display("FAIL rfc_model got=%h", ks); end
    total++;
    if (lat != 20) begin bad++; $display("FAIL rfc_latency got=%0d want=20", lat); end
    finish_block();
  endtask

  task automatic test_zero();
    logic [511:0] ks;
    int lat;
    start_block('0, 32'd0, '0, ks, lat);
    total++;
    if (ks[63:0] !== {32'h903df1a0, 32'hade0b876})
      begin bad++; $display("FAIL zero_words got=%h want=903df1a0ade0b876", ks[63:0]); end
    finish_block();
  endtask

  task automatic test_random();
    logic [511:0] ks;
    logic [255:0] k;
    logic [31:0]  c;
    logic [95:0]  n;
    int lat;
    for (int it = 0; it < 6; it++) begin
      k = rand_key();
      c = (it == 0) ? 32'hffffffff : $urandom;
      n = {$urandom, $urandom, $urandom};
      start_block(k, c, n, ks, lat);
      total++;
      if (ks !== chacha_ref(k, c, n, 10)) begin bad++; $display("FAIL random_block it=%0d got=%h", it, ks); end
      total++;
      if (lat != 20) begin bad++; $display("FAIL random_latency it=%0d got=%0d want=20", it, lat); end
      finish_block();
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] ks;
    logic [255:0] k;
    int lat;
    k = rand_key();
    start_block(k, 32'd7, 96'h1234, ks, lat);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin start_valid = 1'b1; counter_i = 32'd99; end
      @(posedge clock); #1;
      start_valid = 1'b0;
      total++;
      if (keystream !== ks || ks_valid !== 1'b1 || start_ready !== 1'b0)
        begin bad++; $display("FAIL backpressure c=%0d got valid=%0b ready=%0b", c, ks_valid, start_ready); end
    end
    total++;
    if (ks !== chacha_ref(k, 32'd7, 96'h1234, 10)) begin bad++; $display("FAIL backpressure_block got=%h", ks); end
    finish_block();
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      total++;
      if (ks_valid !== 1'b0 || busy !== 1'b0)
        begin bad++; $display("FAIL ignored_start c=%0d got valid=%0b busy=%0b want 0/0", c, ks_valid, busy); end
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] ks [2];
    int at [2];
    int found = 0;
    logic [255:0] k;
    logic [95:0] n;
    k = rand_key();
    n = {$urandom, $urandom, $urandom};
    key_i = k; nonce_i = n; counter_i = 32'd1; start_valid = 1'b1; ks_ready = 1'b1;
    @(posedge clock); #1;
    counter_i = 32'd2;
    for (int cyc = 1; cyc <= 80 && found < 2; cyc++) begin
      @(posedge clock); #1;
      if (ks_valid === 1'b1) begin
        ks[found] = keystream; at[found] = cyc; found++;
        if (found == 2) start_valid = 1'b0;
      end
    end
    start_valid = 1'b0;
    @(posedge clock); #1;
    ks_ready = 1'b0;
    total++;
    if (found != 2) begin
      bad++; $display("FAIL b2b_count got=%0d want=2", found);
    end else begin
      total++;
      if (at[0] != 20 || at[1] - at[0] != 22)
        begin bad++; $display("FAIL b2b_spacing got first=%0d gap=%0d want 20/22", at[0], at[1] - at[0]); end
      total++;
      if (ks[0] !== chacha_ref(k, 32'd1, n, 10) || ks[1] !== chacha_ref(k, 32'd2, n, 10))
        begin bad++; $display("FAIL b2b_blocks got0=%h got1=%h", ks[0][63:0], ks[1][63:0]); end
      total++;
      if (ks[0][31:0] === ks[1][31:0]) begin bad++; $display("FAIL b2b_word0 got=%h want different", ks[1][31:0]); end
    end
    total++;
    if (start_ready !== 1'b1 || busy !== 1'b0)
      begin bad++; $display("FAIL b2b_idle got ready=%0b busy=%0b want 1/0", start_ready, busy); end
  endtask

  task automatic test_reset_mid();
    key_i = rfc_key(); counter_i = 32'd1; nonce_i = {32'h0, 32'h4a000000, 32'h09000000};
    start_valid = 1'b1;
    @(posedge clock); #1;
    start_valid = 1'b0;
    repeat (7) begin @(posedge clock); #1; end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if (ks_valid !== 1'b0 || busy !== 1'b0 || keystream !== '0)
      begin bad++; $display("FAIL reset_mid got valid=%0b busy=%0b ks0=%h want 0/0/0", ks_valid, busy, keystream[31:0]); end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    test_reset();
    test_rfc();
  endtask

  task automatic test_chacha8();
    logic [255:0] k;
    logic [95:0]  n;
    int lat;
    for (int it = 0; it < 2; it++) begin
      k = rand_key(); n = {$urandom, $urandom, $urandom};
      key_i = k; counter_i = 32'(it + 5); nonce_i = n; start_valid8 = 1'b1;
      @(posedge clock); #1;
      start_valid8 = 1'b0;
      lat = 0;
      while (ks_valid8 !== 1'b1 && lat < 200) begin @(posedge clock); #1; lat++; end
      total++;
      if (lat != 8) begin bad++; $display("FAIL chacha8_latency got=%0d want=8", lat); end
      total++;
      if (keystream8 !== chacha_ref(k, 32'(it + 5), n, 4))
        begin bad++; $display("FAIL chacha8_block it=%0d got=%h", it, keystream8[127:0]); end
      ks_ready8 = 1'b1;
      @(posedge clock); #1;
      ks_ready8 = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start_valid = 1'b0; ks_ready = 1'b0; start_valid8 = 1'b0; ks_ready8 = 1'b0;
    key_i = '0; counter_i = '0; nonce_i = '0;
    #2 test_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    test_reset();
    test_rfc();
    test_zero();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_chacha8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
